// File: rtl/vgg_pkg.sv
// vgg_pkg: FP32 types, constants and the sign-magnitude max shared by the VGG datapath blocks.
package vgg_pkg;
   localparam int FP32_WIDTH = 32;
   typedef logic [FP32_WIDTH-1:0] fp32_t;
   localparam fp32_t FP32_POS_ZERO = '0;
   // Sign-magnitude order on raw bits; NaN gets no special treatment.
   function automatic fp32_t fp32_max(input fp32_t a, input fp32_t b);
      return (a[FP32_WIDTH-1] != b[FP32_WIDTH-1]) ? (a[FP32_WIDTH-1] ? b : a) :
             ((a[FP32_WIDTH-1] ? (a < b) : (a > b)) ? a : b);
   endfunction
endpackage

// File: rtl/fp32_max_cmp.sv
// fp32_max_cmp: combinational two-input FP32 maximum.
module fp32_max_cmp
   import vgg_pkg::*;
(
   input  logic [FP32_WIDTH-1:0] a,
   input  logic [FP32_WIDTH-1:0] b,
   output logic [FP32_WIDTH-1:0] y
);
   assign y = fp32_max(a, b);
endmodule

// File: rtl/max_pool_2x2_stream.sv
// max_pool_2x2_stream: streaming 2x2 stride-2 FP32 max-pool over a raster-order square map.
// Define MAX_POOL_RELU_EN to clamp negative pooled results (including -0) to +0.
module max_pool_2x2_stream
   import vgg_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int IMAGE_WIDTH = 112
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_done
);
   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int NB = IMAGE_WIDTH / 2;
   localparam int AW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST = CW'(IMAGE_WIDTH - 1);
   logic [CW-1:0] col_q, col_d, row_q, row_d;
   fp32_t h_q, h_d, o_data_q, o_data_d, hmax, vmax, lb_rd, res;
   logic o_valid_q, o_valid_d, o_done_q, o_done_d, fire, lb_we;
   logic [AW-1:0] idx;
   fp32_t lbuf [NB];
   assign idx   = AW'(col_q >> 1);
   assign lb_rd = lbuf[idx];
   fp32_max_cmp u_hmax (.a(h_q), .b(i_data), .y(hmax));
   fp32_max_cmp u_vmax (.a(lb_rd), .b(hmax), .y(vmax));
   always_comb begin
      fire      = i_valid & col_q[0] & row_q[0];
      lb_we     = i_valid & col_q[0] & ~row_q[0];
      col_d     = i_valid ? ((col_q == LAST) ? '0 : col_q + 1'b1) : col_q;
      row_d     = (i_valid && col_q == LAST) ? ((row_q == LAST) ? '0 : row_q + 1'b1) : row_q;
      h_d       = (i_valid & ~col_q[0]) ? i_data : h_q;
`ifdef MAX_POOL_RELU_EN
      res       = vmax[FP32_WIDTH-1] ? FP32_POS_ZERO : vmax;
`else
      res       = vmax;
`endif
      o_valid_d = fire;
      o_done_d  = fire && col_q == LAST && row_q == LAST;
      o_data_d  = fire ? res : o_data_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q     <= '0;
         row_q     <= '0;
         h_q       <= '0;
         o_valid_q <= 1'b0;
         o_done_q  <= 1'b0;
         o_data_q  <= FP32_POS_ZERO;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         h_q       <= h_d;
         o_valid_q <= o_valid_d;
         o_done_q  <= o_done_d;
         o_data_q  <= o_data_d;
      end
   end
   // Line buffer holds the even-row pair maxima; intentionally not reset.
   always_ff @(posedge clk) begin
      if (lb_we) lbuf[idx] <= hmax;
   end
   assign o_valid = o_valid_q;
   assign o_done  = o_done_q;
   assign o_data  = o_data_q;
endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// tb_max_pool_2x2_stream: table vectors, directed corner sequences and random frames against a reference model.
module tb_max_pool_2x2_stream;
   localparam int W = 4;
   localparam int N = W * W;
   logic clk = 0, rst_n = 0, i_valid = 0;
   logic [31:0] i_data = 0, o_data;
   logic o_valid, o_done;
   int cyc = 0, n_vec = 0, n_err = 0, col = 0, row = 0;
   typedef struct {int due; logic [31:0] d; logic dn;} exp_t;
   typedef struct {logic [31:0] p[4]; logic [31:0] e;} vec_t;
   exp_t q[$];
   logic [31:0] ovr[$];
   logic [31:0] frame[N];
   logic [31:0] ramp[N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
   vec_t tbl[5];

   max_pool_2x2_stream #(.DATA_WIDTH(32), .IMAGE_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_valid(o_valid), .o_data(o_data), .o_done(o_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Map a float bit pattern to an unsigned key whose order is the sign-magnitude order.
   function automatic logic [31:0] key(input logic [31:0] x);
      return x[31] ? ~x : {1'b1, x[30:0]};
   endfunction
   function automatic logic [31:0] fmax_ref(input logic [31:0] a, input logic [31:0] b);
      return (key(a) >= key(b)) ? a : b;
   endfunction
   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MAX_POOL_RELU_EN
      return x[31] ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         i_valid = 0;
      end
   endtask

   task automatic send(input logic [31:0] d);
      logic [31:0] m, e;
      @(posedge clk); #1;
      i_valid = 1;
      i_data  = d;
      if (col % 2 == 1 && row % 2 == 1) begin
         m = fmax_ref(fmax_ref(frame[(row-1)*W+col-1], frame[(row-1)*W+col]),
                      fmax_ref(frame[row*W+col-1], frame[row*W+col]));
         e = (ovr.size() > 0) ? ovr.pop_front() : relu(m);
         q.push_back('{cyc + 1, e, (row == W-1 && col == W-1)});
      end
      col = (col == W-1) ? 0 : col + 1;
      if (col == 0) row = (row == W-1) ? 0 : row + 1;
   endtask

   task automatic run_frame(input int mode);
      for (int i = 0; i < N; i++) begin
         idle(mode == 1 ? 1 : mode == 2 ? int'($urandom_range(0, 3)) : 0);
         send(frame[i]);
      end
   endtask

   task automatic load_spec;
      frame = ramp;
      ovr = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
   endtask

   function automatic logic [31:0] rnd_pix();
      int s = int'($urandom_range(0, 7));
      return s == 0 ? 32'h0 : s == 1 ? 32'h80000000 : s == 2 ? 32'hBF800000 : $urandom;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         while (q.size() > 0 && q[0].due < cyc) begin
            chk("output_late", 32'(cyc), 32'(q[0].due));
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("o_valid", 32'(o_valid), 32'h1);
            chk("o_data", o_data, q[0].d);
            chk("o_done", 32'(o_done), 32'(q[0].dn));
            void'(q.pop_front());
         end else begin
            chk("idle_o_valid", 32'(o_valid), 32'h0);
            chk("idle_o_done", 32'(o_done), 32'h0);
         end
      end
   end

   initial begin
      tbl[0] = '{'{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000}, relu(32'hBF000000)};
      tbl[1] = '{'{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000}, 32'h00000000};
      tbl[2] = '{'{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}, relu(32'h80000000)};
      tbl[3] = '{'{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000}, 32'h40000000};
      tbl[4] = '{'{32'h7F800000, 32'h7FC00000, 32'h00000001, 32'hFF800000}, 32'h7FC00000};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_o_valid", 32'(o_valid), 32'h0);
      chk("reset_o_data", o_data, 32'h0);
      chk("reset_o_done", 32'(o_done), 32'h0);
      rst_n = 1;
      load_spec();
      run_frame(0);
      idle(3);
      for (int t = 0; t < 5; t++) begin
         for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) frame[(2*(k/2) + j/2)*W + 2*(k%2) + j%2] = tbl[t].p[j];
            ovr.push_back(tbl[t].e);
         end
         run_frame(0);
         idle(2);
      end
      load_spec();
      run_frame(1);
      idle(2);
      load_spec();
      run_frame(2);
      idle(3);
      load_spec();
      for (int i = 0; i < 7; i++) send(frame[i]);
      @(posedge clk); #1;
      i_valid = 0;
      chk("pre_reset_o_data", o_data, 32'h40C00000);
      rst_n = 0;
      #1;
      chk("mid_reset_o_valid", 32'(o_valid), 32'h0);
      chk("mid_reset_o_data", o_data, 32'h0);
      chk("mid_reset_o_done", 32'(o_done), 32'h0);
      q.delete();
      ovr.delete();
      col = 0;
      row = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      load_spec();
      run_frame(0);
      idle(2);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < N; i++) frame[i] = rnd_pix();
         run_frame(0);
      end
      idle(3);
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) frame[i] = rnd_pix();
         run_frame(int'($urandom_range(0, 2)));
      end
      idle(4);
      chk("pending_outputs", 32'(q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
